// File: rtl/psram_qpi_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : psram_qpi_ctrl                                             |
// | Description : PSRAM controller. Runs the SPI power-up sequence           |
// |               (RSTEN 0x66, RST 0x99, enter-QPI 0x35) and then serves     |
// |               single/burst QPI reads (0xEB) and writes (0x02) with a     |
// |               24-bit address and fixed read latency.                     |
// | Ports       : mem_clk/rst_n        clock, synchronous active-low reset   |
// |               req/rw/addr/beats    request strobe, 1=write, start, count |
// |               wdata/wdata_ready    write word and its capture strobe     |
// |               rdata/rdata_valid    read word and its strobe              |
// |               init_done/busy/done  status, done is a 1-cycle end pulse   |
// |               mem_ce_n, sclk_en    chip enable, SCLK gate (~mem_clk)     |
// |               sio_out/sio_oe/sio_in quad data pads                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module psram_qpi_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 23,
   parameter int MAX_BEATS      = 8,
   parameter int WAIT_CYCLES    = 6,
   parameter int INIT_CYCLES    = 12800,
   parameter int CE_HIGH_CYCLES = 2     // must be at least 1
) (
   input  logic                           mem_clk,
   input  logic                           rst_n,
   input  logic                           req,
   input  logic                           rw,
   input  logic [ADDR_WIDTH-1:0]          addr,
   input  logic [$clog2(MAX_BEATS+1)-1:0] beats,
   input  logic [DATA_WIDTH-1:0]          wdata,
   output logic                           wdata_ready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic                           rdata_valid,
   output logic                           init_done,
   output logic                           busy,
   output logic                           done,
   output logic                           mem_ce_n,
   output logic                           sclk_en,
   output logic [3:0]                     sio_out,
   output logic [3:0]                     sio_oe,
   input  logic [3:0]                     sio_in
);
   localparam int BEAT_W   = $clog2(MAX_BEATS + 1);
   localparam int NIBBLES  = DATA_WIDTH / 4;
   localparam int CNT_MAX0 = (INIT_CYCLES > 8) ? INIT_CYCLES : 8;
   localparam int CNT_MAX1 = (WAIT_CYCLES > CNT_MAX0) ? WAIT_CYCLES : CNT_MAX0;
   localparam int CNT_MAX  = (CE_HIGH_CYCLES > CNT_MAX1) ? CE_HIGH_CYCLES : CNT_MAX1;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [3:0] ST_INIT_WAIT = 4'd0;
   localparam logic [3:0] ST_RSTEN     = 4'd1;
   localparam logic [3:0] ST_RST       = 4'd2;
   localparam logic [3:0] ST_SPI2QPI   = 4'd3;
   localparam logic [3:0] ST_IDLE      = 4'd4;
   localparam logic [3:0] ST_CMD       = 4'd5;
   localparam logic [3:0] ST_ADDR      = 4'd6;
   localparam logic [3:0] ST_WAIT      = 4'd7;
   localparam logic [3:0] ST_DATA      = 4'd8;
   localparam logic [3:0] ST_CE_GAP    = 4'd9;

   logic [3:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;         // cycle / bit / nibble counter
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [BEAT_W-1:0]     beats_q, beats_d;
   logic [1:0]            init_step_q, init_step_d; // which SPI command the gap follows
   logic                  init_done_q, init_done_d;
   logic                  rw_q, rw_d;
   logic [23:0]           addr_q, addr_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;           // write-out / read-in shift register
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_valid_q, rdata_valid_d;

   logic                  w_nib_last;
   logic                  w_beat_last;
   logic [7:0]            w_spi_byte;
   logic [7:0]            w_cmd;
   logic [23:0]           w_addr_sh;

   assign w_nib_last  = (cnt_q == CNT_W'(NIBBLES - 1));
   assign w_beat_last = (beat_q == beats_q - 1'b1);
   assign w_spi_byte  = (state_q == ST_RSTEN) ? 8'h66 :
                        (state_q == ST_RST)   ? 8'h99 : 8'h35;
   assign w_cmd       = rw_q ? 8'h02 : 8'hEB;
   assign w_addr_sh   = addr_q << {cnt_q[2:0], 2'b00};

   // state register
   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         state_q       <= ST_INIT_WAIT;
         cnt_q         <= '0;
         beat_q        <= '0;
         beats_q       <= '0;
         init_step_q   <= '0;
         init_done_q   <= 1'b0;
         rw_q          <= 1'b0;
         addr_q        <= '0;
         sh_q          <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         beat_q        <= beat_d;
         beats_q       <= beats_d;
         init_step_q   <= init_step_d;
         init_done_q   <= init_done_d;
         rw_q          <= rw_d;
         addr_q        <= addr_d;
         sh_q          <= sh_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      beat_d        = beat_q;
      beats_d       = beats_q;
      init_step_d   = init_step_q;
      init_done_d   = init_done_q;
      rw_d          = rw_q;
      addr_d        = addr_q;
      sh_d          = sh_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      case (state_q)
         ST_INIT_WAIT: begin
            if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
               state_d     = ST_RSTEN;
               cnt_d       = '0;
               init_step_d = 2'd0;
            end
         end
         ST_RSTEN, ST_RST, ST_SPI2QPI: begin
            if (cnt_q == CNT_W'(7)) begin
               state_d = ST_CE_GAP;
               cnt_d   = '0;
            end
         end
         ST_CE_GAP: begin
            if (cnt_q == CNT_W'(CE_HIGH_CYCLES - 1)) begin
               cnt_d = '0;
               if (init_done_q) begin
                  state_d = ST_IDLE;
               end else begin
                  case (init_step_q)
                     2'd0:    begin state_d = ST_RST;     init_step_d = 2'd1; end
                     2'd1:    begin state_d = ST_SPI2QPI; init_step_d = 2'd2; end
                     default: begin state_d = ST_IDLE;    init_done_d = 1'b1; end
                  endcase
               end
            end
         end
         ST_IDLE: begin
            cnt_d = '0;
            if (req && init_done_q) begin
               state_d = ST_CMD;
               rw_d    = rw;
               addr_d  = 24'(addr);
               beat_d  = '0;
               if (beats == '0)
                  beats_d = BEAT_W'(1);
               else if (beats > BEAT_W'(MAX_BEATS))
                  beats_d = BEAT_W'(MAX_BEATS);
               else
                  beats_d = beats;
               if (rw)
                  sh_d = wdata;
            end
         end
         ST_CMD: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_ADDR;
               cnt_d   = '0;
            end
         end
         ST_ADDR: begin
            if (cnt_q == CNT_W'(5)) begin
               cnt_d   = '0;
               state_d = (!rw_q && (WAIT_CYCLES > 0)) ? ST_WAIT : ST_DATA;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_DATA: begin
            if (rw_q)
               sh_d = sh_q << 4;
            else
               sh_d = {sh_q[DATA_WIDTH-5:0], sio_in};
            if (w_nib_last) begin
               cnt_d = '0;
               if (!rw_q) begin
                  rdata_d       = {sh_q[DATA_WIDTH-5:0], sio_in};
                  rdata_valid_d = 1'b1;
               end
               if (w_beat_last) begin
                  state_d = ST_CE_GAP;
               end else begin
                  beat_d = beat_q + 1'b1;
                  if (rw_q)
                     sh_d = wdata;   // next word captured on the wdata_ready pulse
               end
            end
         end
         default: begin
            state_d = ST_INIT_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   // output logic
   always_comb begin
      mem_ce_n    = 1'b1;
      sclk_en     = 1'b0;
      sio_out     = 4'h0;
      sio_oe      = 4'h0;
      wdata_ready = 1'b0;
      done        = 1'b0;
      case (state_q)
         ST_RSTEN, ST_RST, ST_SPI2QPI: begin
            mem_ce_n = 1'b0;
            sclk_en  = 1'b1;
            sio_oe   = 4'b0001;
            sio_out  = {3'b000, w_spi_byte[3'd7 - cnt_q[2:0]]};
         end
         ST_IDLE: begin
            wdata_ready = req && rw && init_done_q;
         end
         ST_CMD: begin
            mem_ce_n = 1'b0;
            sclk_en  = 1'b1;
            sio_oe   = 4'hF;
            sio_out  = cnt_q[0] ? w_cmd[3:0] : w_cmd[7:4];
         end
         ST_ADDR: begin
            mem_ce_n = 1'b0;
            sclk_en  = 1'b1;
            sio_oe   = 4'hF;
            sio_out  = w_addr_sh[23:20];
         end
         ST_WAIT: begin
            mem_ce_n = 1'b0;
            sclk_en  = 1'b1;
         end
         ST_DATA: begin
            mem_ce_n = 1'b0;
            sclk_en  = 1'b1;
            if (rw_q) begin
               sio_oe      = 4'hF;
               sio_out     = sh_q[DATA_WIDTH-1 -: 4];
               wdata_ready = w_nib_last && !w_beat_last;
            end
         end
         ST_CE_GAP: begin
            done = init_done_q && (cnt_q == CNT_W'(CE_HIGH_CYCLES - 1));
         end
         default: begin
            mem_ce_n = 1'b1;
         end
      endcase
   end

   assign busy        = init_done_q && (state_q != ST_IDLE);
   assign init_done   = init_done_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire
